// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and the
// lock-loss counter limit.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUNNING   = 2'd3
  } seq_state_e;

  localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;

  // Counter increment that sticks at LOCK_LOSS_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == LOCK_LOSS_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/lock_synchronizer.sv
// Two-flop synchronizer that brings one DCM lock indicator into the board
// clock domain; both stages clear to 0 (unlocked) on reset.
module lock_synchronizer (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make sync_q take the pre-edge meta_q,
  // which is what gives two distinct flop stages.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Turns the two DCM lock indicators into staged, registered reset releases
// (SRAM, then main, then user) and re-asserts everything on any lock loss.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP     = 16
) (
  input  logic       input_clk,
  input  logic       reset,
  input  logic       dcm_locked,
  input  logic       dcm_locked_two,
  output logic       reset_sram,
  output logic       reset_main,
  output logic       reset_user,
  output logic       system_ready,
  output logic [7:0] lock_loss_count,
  output logic [1:0] seq_state
);

  localparam int unsigned SCW = $clog2(STABLE_CYCLES);
  localparam int unsigned GCW = $clog2(STAGE_GAP);
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [GCW-1:0] STAGE_LAST  = GCW'(STAGE_GAP - 1);

  logic lock_main_sync;
  logic lock_two_sync;
  logic lock_ok;

  lock_synchronizer u_sync_main (
    .clk_i   (input_clk),
    .reset_i (reset),
    .async_i (dcm_locked),
    .sync_o  (lock_main_sync)
  );

  lock_synchronizer u_sync_two (
    .clk_i   (input_clk),
    .reset_i (reset),
    .async_i (dcm_locked_two),
    .sync_o  (lock_two_sync)
  );

  assign lock_ok = lock_main_sync & lock_two_sync;

  seq_state_e     state_q,        state_d;
  logic [SCW-1:0] stable_cnt_q,   stable_cnt_d;
  logic [GCW-1:0] stage_cnt_q,    stage_cnt_d;
  logic           reset_sram_q,   reset_sram_d;
  logic           reset_main_q,   reset_main_d;
  logic           reset_user_q,   reset_user_d;
  logic           ready_q,        ready_d;
  logic [7:0]     loss_cnt_q,     loss_cnt_d;

  always_ff @(posedge input_clk) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      stable_cnt_q <= '0;
      stage_cnt_q  <= '0;
      reset_sram_q <= 1'b1;
      reset_main_q <= 1'b1;
      reset_user_q <= 1'b1;
      ready_q      <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      stage_cnt_q  <= stage_cnt_d;
      reset_sram_q <= reset_sram_d;
      reset_main_q <= reset_main_d;
      reset_user_q <= reset_user_d;
      ready_q      <= ready_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its register first, so no path through
    // this block leaves a signal unassigned and infers a latch.
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    stage_cnt_d  = stage_cnt_q;
    reset_sram_d = reset_sram_q;
    reset_main_d = reset_main_q;
    reset_user_d = reset_user_q;
    ready_d      = ready_q;
    loss_cnt_d   = loss_cnt_q;

    if (!lock_ok) begin
      // Lock loss wins over sequencing and re-asserts every reset at once.
      state_d      = WAIT_LOCK;
      reset_sram_d = 1'b1;
      reset_main_d = 1'b1;
      reset_user_d = 1'b1;
      ready_d      = 1'b0;
      if (state_q == RELEASE || state_q == RUNNING) begin
        loss_cnt_d = sat_inc(loss_cnt_q);
      end
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_d      = STABILIZE;
          stable_cnt_d = '0;
        end
        STABILIZE: begin
          if (stable_cnt_q == STABLE_LAST) begin
            state_d      = RELEASE;
            reset_sram_d = 1'b0;
            stage_cnt_d  = '0;
          end else begin
            stable_cnt_d = stable_cnt_q + SCW'(1);
          end
        end
        RELEASE: begin
          // reset_main still high means the second stage is pending.
          if (stage_cnt_q == STAGE_LAST) begin
            if (reset_main_q) begin
              reset_main_d = 1'b0;
              stage_cnt_d  = '0;
            end else begin
              reset_user_d = 1'b0;
              ready_d      = 1'b1;
              state_d      = RUNNING;
            end
          end else begin
            stage_cnt_d = stage_cnt_q + GCW'(1);
          end
        end
        RUNNING: begin
        end
      endcase
    end
  end

  assign reset_sram      = reset_sram_q;
  assign reset_main      = reset_main_q;
  assign reset_user      = reset_user_q;
  assign system_ready    = ready_q;
  assign lock_loss_count = loss_cnt_q;
  assign seq_state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus pushes expected output
// snapshots tagged with an edge number; a monitor compares them at negedge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       dcm_locked;
  logic       dcm_locked_two;
  logic       reset_sram;
  logic       reset_main;
  logic       reset_user;
  logic       system_ready;
  logic [7:0] lock_loss_count;
  logic [1:0] seq_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_no      = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [13:0] snap;
  } exp_t;

  exp_t sb[$];

  reset_sequencer #(
    .STABLE_CYCLES (8),
    .STAGE_GAP     (4)
  ) dut (
    .input_clk       (clk),
    .reset           (reset),
    .dcm_locked      (dcm_locked),
    .dcm_locked_two  (dcm_locked_two),
    .reset_sram      (reset_sram),
    .reset_main      (reset_main),
    .reset_user      (reset_user),
    .system_ready    (system_ready),
    .lock_loss_count (lock_loss_count),
    .seq_state       (seq_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Snapshot layout: {sram, main, user, ready, count[7:0], state[1:0]}.
  function automatic logic [13:0] snap(logic s, logic m, logic u, logic r,
                                       logic [7:0] c, logic [1:0] st);
    return {s, m, u, r, c, st};
  endfunction

  function automatic logic [13:0] st_wait(logic [7:0] c); return snap(1, 1, 1, 0, c, 2'd0); endfunction
  function automatic logic [13:0] st_stab(logic [7:0] c); return snap(1, 1, 1, 0, c, 2'd1); endfunction
  function automatic logic [13:0] st_rel1(logic [7:0] c); return snap(0, 1, 1, 0, c, 2'd2); endfunction
  function automatic logic [13:0] st_rel2(logic [7:0] c); return snap(0, 0, 1, 0, c, 2'd2); endfunction
  function automatic logic [13:0] st_run(logic [7:0] c);  return snap(0, 0, 0, 1, c, 2'd3); endfunction

  task automatic push(int cyc, string name, logic [13:0] s);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.snap = s;
    sb.push_back(e);
  endtask

  task automatic check(string name, int cyc, logic [13:0] got, logic [13:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s (edge %0d): got srst/main/user/rdy=%b cnt=%0d state=%0d, want %b cnt=%0d state=%0d",
               name, cyc, got[13:10], got[9:2], got[1:0], want[13:10], want[9:2], want[1:0]);
    end
  endtask

  // Monitor: compare every expectation whose edge has just happened.
  always @(negedge clk) begin
    logic [13:0] now;
    now = {reset_sram, reset_main, reset_user, system_ready, lock_loss_count, seq_state};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edge_no) begin
        check(sb[i].name, edge_no, now, sb[i].snap);
        sb.delete(i);
      end else if (sb[i].cyc < edge_no) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s: expectation for edge %0d never compared (now %0d)", sb[i].name, sb[i].cyc, edge_no);
        sb.delete(i);
      end
    end
  end

  task automatic wait_edges(int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected release sequence when edge base+1 is the first to sample both locks high.
  task automatic cold_expect(int base, logic [7:0] c);
    push(base + 2,  "sync_wait",   st_wait(c));
    push(base + 3,  "enter_stab",  st_stab(c));
    push(base + 10, "still_stab",  st_stab(c));
    push(base + 11, "sram_rel",    st_rel1(c));
    push(base + 14, "main_held",   st_rel1(c));
    push(base + 15, "main_rel",    st_rel2(c));
    push(base + 18, "user_held",   st_rel2(c));
    push(base + 19, "user_rel",    st_run(c));
  endtask

  task automatic reset_pulse();
    reset          = 1'b1;
    dcm_locked     = 1'b0;
    dcm_locked_two = 1'b0;
    for (int i = 1; i <= 3; i++) push(edge_no + i, "reset_state", st_wait(8'd0));
    wait_edges(3);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int k;

    // Cold start
    reset_pulse();
    base = edge_no;
    dcm_locked     = 1'b1;
    dcm_locked_two = 1'b1;
    cold_expect(base, 8'd0);
    wait_edges(20);

    // Loss in RUNNING, then relock
    dcm_locked = 1'b0;
    k = edge_no + 1;
    push(k + 1, "loss_latency", st_run(8'd0));
    push(k + 2, "loss_run",     st_wait(8'd1));
    wait_edges(4);
    push(edge_no + 1, "loss_idle", st_wait(8'd1));
    dcm_locked = 1'b1;
    base = edge_no;
    cold_expect(base, 8'd1);
    wait_edges(20);

    // Settle abort: lock_two low for edges 6 and 7
    reset_pulse();
    base = edge_no;
    dcm_locked     = 1'b1;
    dcm_locked_two = 1'b1;
    push(base + 7,  "abort_pre",    st_stab(8'd0));
    push(base + 8,  "abort_wait",   st_wait(8'd0));
    push(base + 11, "abort_no_rel", st_stab(8'd0));
    cold_expect(base + 7, 8'd0);
    wait_edges(5);
    dcm_locked_two = 1'b0;
    wait_edges(2);
    dcm_locked_two = 1'b1;
    wait_edges(20);

    // Mid-RELEASE loss: lock low sampled at edge 12
    reset_pulse();
    base = edge_no;
    dcm_locked     = 1'b1;
    dcm_locked_two = 1'b1;
    push(base + 12, "midrel_12",   st_rel1(8'd0));
    push(base + 13, "midrel_13",   st_rel1(8'd0));
    push(base + 14, "midrel_loss", st_wait(8'd1));
    push(base + 15, "midrel_main", st_wait(8'd1));
    push(base + 20, "midrel_idle", st_wait(8'd1));
    wait_edges(11);
    dcm_locked = 1'b0;
    wait_edges(9);
    dcm_locked = 1'b1;
    base = edge_no;
    cold_expect(base, 8'd1);
    wait_edges(20);

    // Saturation: 260 loss/relock cycles, each dropping lock in RELEASE
    reset_pulse();
    for (int i = 1; i <= 260; i++) begin
      logic [7:0] want_cnt;
      want_cnt = (i > 255) ? 8'd255 : 8'(i);
      base = edge_no;
      dcm_locked     = 1'b1;
      dcm_locked_two = 1'b1;
      if (i == 1) push(base + 11, "sat_first_rel", st_rel1(8'd0));
      push(base + 15, "sat_count", st_wait(want_cnt));
      wait_edges(12);
      dcm_locked = 1'b0;
      wait_edges(4);
    end
    dcm_locked = 1'b1;
    base = edge_no;
    cold_expect(base, 8'd255);
    wait_edges(20);

    // reset coinciding with a RUNNING lock loss
    dcm_locked = 1'b0;
    k = edge_no + 1;
    push(k + 1, "rstloss_pre", st_run(8'd255));
    wait_edges(2);
    reset = 1'b1;
    push(k + 2, "rstloss_edge", st_wait(8'd0));
    wait_edges(1);
    reset = 1'b0;
    push(k + 4, "rstloss_after", st_wait(8'd0));
    wait_edges(4);

    foreach (sb[i]) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: expectation for edge %0d left unchecked", sb[i].name, sb[i].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
